// File: rtl/traffic_pkg.sv
// Shared constants for the traffic phase sequencer: state codes, lamp codes,
// default phase lengths and the fixed phase order.
package traffic_pkg;

  localparam logic [2:0] ST_NS_G  = 3'd0;
  localparam logic [2:0] ST_NS_Y  = 3'd1;
  localparam logic [2:0] ST_CLR1  = 3'd2;
  localparam logic [2:0] ST_EW_G  = 3'd3;
  localparam logic [2:0] ST_EW_Y  = 3'd4;
  localparam logic [2:0] ST_CLR2  = 3'd5;
  localparam logic [2:0] ST_FLASH = 3'd6;

  localparam logic [2:0] RGY_RED = 3'b100;
  localparam logic [2:0] RGY_YEL = 3'b010;
  localparam logic [2:0] RGY_GRN = 3'b001;
  localparam logic [2:0] RGY_OFF = 3'b000;

  localparam int DEF_GREEN_TICKS     = 25;
  localparam int DEF_YELLOW_TICKS    = 3;
  localparam int DEF_CLEAR_TICKS     = 2;
  localparam int DEF_MIN_GREEN_TICKS = 5;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamp_pair_t;

  function automatic logic [2:0] next_phase(input logic [2:0] st);
    case (st)
      ST_NS_G: next_phase = ST_NS_Y;
      ST_NS_Y: next_phase = ST_CLR1;
      ST_CLR1: next_phase = ST_EW_G;
      ST_EW_G: next_phase = ST_EW_Y;
      ST_EW_Y: next_phase = ST_CLR2;
      default: next_phase = ST_NS_G;
    endcase
  endfunction

  function automatic lamp_pair_t lamps_of(input logic [2:0] st);
    case (st)
      ST_NS_G:  lamps_of = '{ns: RGY_GRN, ew: RGY_RED};
      ST_NS_Y:  lamps_of = '{ns: RGY_YEL, ew: RGY_RED};
      ST_EW_G:  lamps_of = '{ns: RGY_RED, ew: RGY_GRN};
      ST_EW_Y:  lamps_of = '{ns: RGY_RED, ew: RGY_YEL};
      ST_FLASH: lamps_of = '{ns: RGY_YEL, ew: RGY_YEL};
      default:  lamps_of = '{ns: RGY_RED, ew: RGY_RED};
    endcase
  endfunction

endpackage

// File: rtl/phase_gap_gen.sv
// Timer enable gap and blanking: drops en30 for one cycle after every phase change
// and masks c30 until the timer has run one full enabled cycle from zero.
module phase_gap_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic phase_change,
  input  logic c30,
  output logic en30,
  output logic tick_accept
);

  logic blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en30  <= 1'b0;
      blank <= 1'b1;
    end else begin
      en30 <= ~phase_change;
      if (phase_change)
        blank <= 1'b1;
      else if (en30)
        blank <= 1'b0;
    end
  end

  assign tick_accept = c30 & en30 & ~blank;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase sequencer: counts accepted timer ticks per phase, drives lamps,
// walk lamp and the per-phase countdown.
//   state | meaning
//   NS_G  | north-south green          NS_Y  | north-south yellow
//   CLR1  | all-red before east-west   EW_G  | east-west green
//   EW_Y  | east-west yellow           CLR2  | all-red before north-south
//   FLASH | night flash, both yellows toggle per tick
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS     = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS    = DEF_YELLOW_TICKS,
  parameter int CLEAR_TICKS     = DEF_CLEAR_TICKS,
  parameter int MIN_GREEN_TICKS = DEF_MIN_GREEN_TICKS,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c30,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic             en30,
  output logic [2:0]       ns_rgy,
  output logic [2:0]       ew_rgy,
  output logic             ped_walk,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase
);

  localparam int CW1 = CNT_W + 1;

  logic             ped_pend;
  logic             tick_accept;
  logic             phase_change;
  logic             ped_cut;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] remain_nx;
  lamp_pair_t       lamp_nx;

  function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] st);
    case (st)
      ST_NS_G, ST_EW_G: phase_len = CNT_W'(GREEN_TICKS);
      ST_NS_Y, ST_EW_Y: phase_len = CNT_W'(YELLOW_TICKS);
      ST_CLR1, ST_CLR2: phase_len = CNT_W'(CLEAR_TICKS);
      default:          phase_len = '0;
    endcase
  endfunction

  phase_gap_gen u_gap (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase_change (phase_change),
    .c30          (c30),
    .en30         (en30),
    .tick_accept  (tick_accept)
  );

  // Elapsed green ticks including this one is GREEN - remain + 1; compared without subtraction.
  assign ped_cut = ((phase == ST_NS_G) || (phase == ST_EW_G)) && ped_pend &&
                   (CW1'(GREEN_TICKS + 1) >= ({1'b0, remain} + CW1'(MIN_GREEN_TICKS)));

  always_comb begin
    state_nx  = phase;
    remain_nx = remain;
    if (phase == ST_FLASH) begin
      remain_nx = '0;
      if (!flash_mode) begin
        state_nx  = ST_CLR2;
        remain_nx = CNT_W'(CLEAR_TICKS);
      end
    end else if (flash_mode) begin
      state_nx  = ST_FLASH;
      remain_nx = '0;
    end else if (tick_accept) begin
      if ((remain <= CNT_W'(1)) || ped_cut) begin
        state_nx  = next_phase(phase);
        remain_nx = phase_len(state_nx);
      end else begin
        remain_nx = remain - 1'b1;
      end
    end
  end

  assign phase_change = (state_nx != phase);
  assign lamp_nx      = lamps_of(state_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= ST_CLR2;
      remain   <= CNT_W'(CLEAR_TICKS);
      ns_rgy   <= RGY_RED;
      ew_rgy   <= RGY_RED;
      ped_walk <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      phase  <= state_nx;
      remain <= remain_nx;
      if (phase_change) begin
        ns_rgy <= lamp_nx.ns;
        ew_rgy <= lamp_nx.ew;
      end else if ((phase == ST_FLASH) && tick_accept) begin
        ns_rgy <= ns_rgy ^ RGY_YEL;
        ew_rgy <= ew_rgy ^ RGY_YEL;
      end
      // A request arriving on the clearance entry edge is kept for the next cycle.
      if (state_nx == ST_FLASH) begin
        ped_pend <= 1'b0;
        ped_walk <= 1'b0;
      end else if (phase_change && ((state_nx == ST_CLR1) || (state_nx == ST_CLR2))) begin
        ped_walk <= ped_pend;
        ped_pend <= ped_req;
      end else begin
        ped_pend <= ped_pend | ped_req;
        if (phase_change)
          ped_walk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a 10-cycle interval timer model
// that holds c30 while disabled.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c30;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic       en30;
  logic [2:0] ns_rgy, ew_rgy;
  logic       ped_walk;
  logic [7:0] remain;
  logic [2:0] phase;

  logic       force_hi = 1'b0;
  logic       tc30;
  int         tcnt;
  int         checks = 0;
  int         failures = 0;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c30        (c30),
    .ped_req    (ped_req),
    .flash_mode (flash_mode),
    .en30       (en30),
    .ns_rgy     (ns_rgy),
    .ew_rgy     (ew_rgy),
    .ped_walk   (ped_walk),
    .remain     (remain),
    .phase      (phase)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 0;
      tc30 <= 1'b0;
    end else if (en30) begin
      tc30 <= (tcnt == 9);
      tcnt <= (tcnt == 9) ? 0 : tcnt + 1;
    end else begin
      tcnt <= 0;
    end
  end

  assign c30 = tc30 | force_hi;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for phase==tgt, counting c30&en30 cycles spent before it; optionally
  // tracks the remain countdown on each tick against len-ticks.
  task automatic wait_phase(input logic [2:0] tgt, input int chk_len, output int ticks,
                            output bit ok, output bit walk_all, output bit rem_ok);
    ticks = 0; ok = 0; walk_all = 1; rem_ok = 1;
    for (int i = 0; i < 400; i++) begin
      if (phase === tgt) begin
        ok = 1;
        break;
      end
      if (c30 && en30) begin
        if (chk_len != 0 && remain !== 8'(chk_len - ticks)) rem_ok = 0;
        ticks++;
      end
      walk_all &= ped_walk;
      step();
    end
  endtask

  task automatic test_reset();
    int t; bit ok, wa, ro;
    ped_req = 0; flash_mode = 0; rst_n = 0;
    #25;
    checks++; if (ns_rgy !== RGY_RED || ew_rgy !== RGY_RED) begin failures++; $display("FAIL reset_lamps: got %b/%b want 100/100", ns_rgy, ew_rgy); end
    checks++; if (en30 !== 1'b0) begin failures++; $display("FAIL reset_en30: got %b want 0", en30); end
    checks++; if (remain !== 8'd2) begin failures++; $display("FAIL reset_remain: got %0d want 2", remain); end
    checks++; if (phase !== ST_CLR2 || ped_walk !== 1'b0) begin failures++; $display("FAIL reset_phase: got %0d walk %b want 5 walk 0", phase, ped_walk); end
    step();
    rst_n = 1;
    step();
    checks++; if (en30 !== 1'b1) begin failures++; $display("FAIL release_en30: got %b want 1", en30); end
    wait_phase(ST_NS_G, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 2) begin failures++; $display("FAIL first_green: ok %0d ticks %0d want 2", ok, t); end
    checks++; if (ns_rgy !== RGY_GRN || ew_rgy !== RGY_RED || remain !== 8'd25) begin failures++; $display("FAIL ns_g_entry: got %b/%b rem %0d want 001/100 rem 25", ns_rgy, ew_rgy, remain); end
    checks++; if (en30 !== 1'b0) begin failures++; $display("FAIL ns_g_gap: got %b want 0", en30); end
    step();
    checks++; if (en30 !== 1'b1) begin failures++; $display("FAIL ns_g_reenable: got %b want 1", en30); end
  endtask

  task automatic test_free_run();
    logic [2:0] fr_ph[6]  = '{ST_NS_Y, ST_CLR1, ST_EW_G, ST_EW_Y, ST_CLR2, ST_NS_G};
    logic [2:0] fr_ns[6]  = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] fr_ew[6]  = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    int         fr_rem[6] = '{3, 2, 25, 3, 2, 25};
    int         fr_dw[6]  = '{25, 3, 2, 25, 3, 2};
    int t; bit ok, wa, ro;
    for (int i = 0; i < 6; i++) begin
      wait_phase(fr_ph[i], (i == 0) ? 25 : 0, t, ok, wa, ro);
      checks++; if (!ok || t != fr_dw[i]) begin failures++; $display("FAIL dwell_%0d: ok %0d ticks %0d want %0d", i, ok, t, fr_dw[i]); end
      if (i == 0) begin
        checks++; if (!ro) begin failures++; $display("FAIL ns_g_countdown: remain sequence not 25..1"); end
      end
      checks++; if (ns_rgy !== fr_ns[i] || ew_rgy !== fr_ew[i]) begin failures++; $display("FAIL lamps_%0d: got %b/%b want %b/%b", i, ns_rgy, ew_rgy, fr_ns[i], fr_ew[i]); end
      checks++; if (remain !== 8'(fr_rem[i])) begin failures++; $display("FAIL load_%0d: got %0d want %0d", i, remain, fr_rem[i]); end
      checks++; if (en30 !== 1'b0) begin failures++; $display("FAIL gap_%0d: got %b want 0", i, en30); end
      step();
      checks++; if (en30 !== 1'b1) begin failures++; $display("FAIL regap_%0d: got %b want 1", i, en30); end
    end
  endtask

  task automatic test_ped_ns();
    int t, last_rem; bit ok, wa, ro;
    t = 0; last_rem = 0; ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (phase !== ST_NS_G) begin ok = 1; break; end
      if (c30 && en30) begin
        t++;
        last_rem = int'(remain);
        if (t == 2) ped_req = 1;
      end
      step();
      ped_req = 0;
    end
    checks++; if (!ok || phase !== ST_NS_Y || t != 5) begin failures++; $display("FAIL ped_ns_cut: phase %0d ticks %0d want 1 ticks 5", phase, t); end
    checks++; if (last_rem != 21) begin failures++; $display("FAIL ped_ns_rem: got %0d want 21", last_rem); end
    wait_phase(ST_CLR1, 0, t, ok, wa, ro);
    checks++; if (!ok || ped_walk !== 1'b1) begin failures++; $display("FAIL ped_walk_clr1: got %b want 1", ped_walk); end
    step();
    wait_phase(ST_EW_G, 0, t, ok, wa, ro);
    checks++; if (!ok || !wa) begin failures++; $display("FAIL ped_walk_hold: ok %0d held %0d want 1", ok, wa); end
    checks++; if (ped_walk !== 1'b0) begin failures++; $display("FAIL ped_walk_ewg: got %b want 0", ped_walk); end
  endtask

  task automatic test_ped_ew_and_clear();
    int t; bit ok, wa, ro;
    t = 0; ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (phase !== ST_EW_G) begin ok = 1; break; end
      if (c30 && en30) begin
        t++;
        if (t == 1) ped_req = 1;
      end
      step();
      ped_req = 0;
    end
    checks++; if (!ok || phase !== ST_EW_Y || t != 5) begin failures++; $display("FAIL ped_ew_cut: phase %0d ticks %0d want 4 ticks 5", phase, t); end
    wait_phase(ST_CLR2, 0, t, ok, wa, ro);
    checks++; if (!ok || ped_walk !== 1'b1) begin failures++; $display("FAIL ped_walk_clr2: got %b want 1", ped_walk); end
    step();
    ped_req = 1;
    step();
    ped_req = 0;
    wait_phase(ST_NS_G, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 2 || !wa || ped_walk !== 1'b0) begin failures++; $display("FAIL clr2_exit: ticks %0d held %0d walk %b want 2 1 0", t, wa, ped_walk); end
    wait_phase(ST_NS_Y, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 5) begin failures++; $display("FAIL clr2_req_cut: ticks %0d want 5", t); end
    wait_phase(ST_CLR1, 0, t, ok, wa, ro);
    checks++; if (!ok || ped_walk !== 1'b1) begin failures++; $display("FAIL clr2_req_walk: got %b want 1", ped_walk); end
  endtask

  task automatic test_flash();
    int t, k; bit ok, wa, ro;
    logic [2:0] exp_y;
    wait_phase(ST_EW_G, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 2) begin failures++; $display("FAIL flash_pre: ticks %0d want 2", t); end
    t = 0;
    for (int i = 0; i < 400; i++) begin
      if (c30 && en30) t++;
      step();
      if (t == 3) break;
    end
    flash_mode = 1;
    step();
    checks++; if (phase !== ST_FLASH || ns_rgy !== RGY_YEL || ew_rgy !== RGY_YEL) begin failures++; $display("FAIL flash_entry: phase %0d %b/%b want 6 010/010", phase, ns_rgy, ew_rgy); end
    checks++; if (en30 !== 1'b0 || remain !== 8'd0 || ped_walk !== 1'b0) begin failures++; $display("FAIL flash_gap: en30 %b rem %0d walk %b want 0 0 0", en30, remain, ped_walk); end
    step();
    checks++; if (en30 !== 1'b1) begin failures++; $display("FAIL flash_reenable: got %b want 1", en30); end
    ped_req = 1;
    step();
    ped_req = 0;
    k = 0;
    for (int i = 0; i < 400 && k < 3; i++) begin
      if (c30 && en30) begin
        k++;
        exp_y = (k % 2 == 1) ? RGY_OFF : RGY_YEL;
        step();
        checks++; if (ns_rgy !== exp_y || ew_rgy !== exp_y) begin failures++; $display("FAIL flash_toggle_%0d: got %b/%b want %b/%b", k, ns_rgy, ew_rgy, exp_y, exp_y); end
      end else begin
        step();
      end
    end
    checks++; if (k != 3) begin failures++; $display("FAIL flash_ticks: got %0d want 3", k); end
    flash_mode = 0;
    step();
    checks++; if (phase !== ST_CLR2 || remain !== 8'd2 || en30 !== 1'b0) begin failures++; $display("FAIL flash_exit: phase %0d rem %0d en30 %b want 5 2 0", phase, remain, en30); end
    checks++; if (ns_rgy !== RGY_RED || ew_rgy !== RGY_RED || ped_walk !== 1'b0) begin failures++; $display("FAIL flash_exit_lamps: %b/%b walk %b want 100/100 0", ns_rgy, ew_rgy, ped_walk); end
    step();
    wait_phase(ST_NS_G, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 2) begin failures++; $display("FAIL flash_clr2_dwell: ticks %0d want 2", t); end
  endtask

  task automatic test_reset_mid();
    int t; bit ok, wa, ro;
    wait_phase(ST_NS_Y, 0, t, ok, wa, ro);
    checks++; if (!ok || t != 25) begin failures++; $display("FAIL post_flash_green: ticks %0d want 25", t); end
    step(); step(); step();
    rst_n = 0;
    #2;
    checks++; if (ns_rgy !== RGY_RED || ew_rgy !== RGY_RED || en30 !== 1'b0) begin failures++; $display("FAIL async_reset: %b/%b en30 %b want 100/100 0", ns_rgy, ew_rgy, en30); end
    checks++; if (phase !== ST_CLR2 || remain !== 8'd2) begin failures++; $display("FAIL async_reset_state: phase %0d rem %0d want 5 2", phase, remain); end
  endtask

  // c30 held high continuously: each phase of L ticks must last exactly L+2 edges.
  task automatic test_gap_stale();
    int e, e_ng;
    force_hi = 1;
    step();
    rst_n = 1;
    e = 0;
    for (int i = 0; i < 20 && phase === ST_CLR2; i++) begin step(); e++; end
    checks++; if (phase !== ST_NS_G || e != 4) begin failures++; $display("FAIL stale_clr2: phase %0d edges %0d want 0 4", phase, e); end
    step(); step(); step();
    checks++; if (remain !== 8'd24) begin failures++; $display("FAIL stale_first_dec: got %0d want 24", remain); end
    e_ng = 3;
    for (int i = 0; i < 60 && phase === ST_NS_G; i++) begin step(); e_ng++; end
    checks++; if (phase !== ST_NS_Y || e_ng != 27) begin failures++; $display("FAIL stale_ns_g: phase %0d edges %0d want 1 27", phase, e_ng); end
    e = 0;
    for (int i = 0; i < 20 && phase === ST_NS_Y; i++) begin step(); e++; end
    checks++; if (phase !== ST_CLR1 || e != 5) begin failures++; $display("FAIL stale_ns_y: phase %0d edges %0d want 2 5", phase, e); end
    force_hi = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_ns();
    test_ped_ew_and_clear();
    test_flash();
    test_reset_mid();
    test_gap_stale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
